main_memory: RTL and testbench
==============================

# main_memory

Block-addressed backing memory model sitting directly downstream of the L2 cache. It serves whole-block reads and writes over the L2 memory interface with a fixed, parameterised latency. An optional open-block buffer returns repeated reads early and signals this on `mem_hit`. It is the bottom of the hierarchy: every L2 allocate terminates here.

## Interface
- `DATA_WIDTH`, 32: bits per word.
- `ADDR_WIDTH`, 32: request address width, in word units.
- `BLOCK_SIZE`, 16: words per block; must be a power of two ≥ 2.
- `NUM_BLOCKS`, 256: storage depth in blocks; must be a power of two.
- `READ_LATENCY`, 20: cycles from read acceptance to `mem_ready`; must be ≥ 2.
- `WRITE_LATENCY`, 20: cycles from write acceptance to `mem_ready`; must be ≥ 2.

Ports:
- `clk`, input, 1: single clock; everything is on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `mem_addr`, input, ADDR_WIDTH: request address.
- `mem_data_in`, input, BLOCK_SIZE×DATA_WIDTH: write block from L2.
- `mem_data_out`, output, BLOCK_SIZE×DATA_WIDTH: read block to L2.
- `mem_read`, input, 1: read request level.
- `mem_write`, input, 1: write request level.
- `mem_ready`, output, 1: one-cycle completion pulse, slow path.
- `mem_hit`, output, 1: one-cycle completion pulse, open-block fast path.

## Operation
Address decode:
- Word offset is `mem_addr[log2(BLOCK_SIZE)-1:0]` and is ignored.
- Block index is the next `log2(NUM_BLOCKS)` bits.
- Higher bits are ignored, so addresses alias modulo the storage size.

Storage:
- Storage is not cleared by reset.
- At time zero, word w of block b holds `b*BLOCK_SIZE + w`, zero-extended.

State machine:
- IDLE: a request is accepted on an edge where `mem_read` or `mem_write` is high. Address, direction and write data are latched. If both are high, write wins. Next state is BUSY, or HIT_RESP for a buffered read.
- BUSY: the latency counter decrements. At expiry the block moves to RESP.
- RESP: a read drives `mem_data_out` from storage. A write commits the latched data to storage. `mem_ready` is 1 for exactly this cycle. Next state is RELEASE.
- HIT_RESP: `mem_data_out` is driven from the open-block buffer. `mem_hit` is 1 for exactly this cycle. Next state is RELEASE.
- RELEASE: the block waits until `mem_read` and `mem_write` are both low, then returns to IDLE. This prevents a request from being re-accepted while L2 is still dropping its request level.

Data and request rules:
- `mem_data_out` holds the last returned block until the next read response. Writes leave it unchanged.
- Request inputs are ignored outside IDLE, and address changes during BUSY have no effect.

## Timing
Reset values:
- `mem_ready`=0, `mem_hit`=0, `mem_data_out`=0.
- State is IDLE and the open buffer is invalid.

Latencies, with acceptance at edge t0:
- Slow read: `mem_ready` is high in the cycle following edge t0+READ_LATENCY, with data valid in that same cycle.
- Write: `mem_ready` is high in the cycle following edge t0+WRITE_LATENCY, and storage is updated on that edge.
- Buffered read: `mem_hit` is high in the cycle following edge t0+1, with data valid in that same cycle.

Back-to-back:
- Minimum spacing between two accepted requests is the response cycle plus one RELEASE cycle in which both request levels are low.

Reset mid-operation:
- The block returns to IDLE immediately and all outputs go to their reset values.
- A pending write is dropped and storage is unchanged.
- The open buffer is invalidated.

Latency counter:
- The counter is `$clog2(max(READ_LATENCY,WRITE_LATENCY))+1` bits wide.
- It loads latency−1 at acceptance.
- It never wraps: a count of 0 in BUSY means expiry.

## Configuration
- `MAIN_MEMORY_OPEN_BLOCK_EN` defined:
  - The block keeps a one-entry buffer holding a block index, its data, and a valid bit.
  - The buffer is loaded on every slow read response and on every write commit. A write updates the buffer with the written data, so the buffer stays coherent.
  - A read whose block index matches a valid buffer entry takes HIT_RESP.
  - Writes never use the fast path.
- Undefined:
  - There is no buffer and `mem_hit` is tied to 0.
  - Every read takes BUSY/RESP.

## Test plan
- Reset, then read `mem_addr`=0x35 with `BLOCK_SIZE`=16: `mem_ready` pulses once, 20 cycles after acceptance. Word w of `mem_data_out` is 0x30+w, and `mem_hit` stays 0.
- Write of block 0xDEAD0000+w to address 0x120, then read 0x12F: the write's `mem_ready` comes after 20 cycles. The read returns 0xDEAD0000+w; with the macro defined it completes via `mem_hit` after 1 cycle.
- With the macro defined, read 0x40 then read 0x50: the second read is a buffer miss and takes 20 cycles via `mem_ready`. A repeat read of 0x50 completes via `mem_hit` after 1 cycle.
- Hold `mem_read` high for 3 cycles after `mem_ready`: exactly one response is produced. A new request is accepted only after `mem_read` is low for at least one cycle.
- Assert `mem_read` and `mem_write` together at 0x200: the block performs the write, and storage at block 0x20 equals `mem_data_in`.
- Assert `rst` 5 cycles into a write to 0x80: outputs return to 0. A following read of 0x80 returns the initial pattern 0x80+w, so the write was dropped.

Source files
------------

// File: rtl/main_memory_if.sv
// Block request/response bus between L2 and main_memory.
interface main_memory_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BLOCK_SIZE = 16
);
    logic [ADDR_WIDTH-1:0]            mem_addr;
    logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_in;
    logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_out;
    logic                             mem_read;
    logic                             mem_write;
    logic                             mem_ready;
    logic                             mem_hit;

    modport master (
        output mem_addr, mem_data_in, mem_read, mem_write,
        input  mem_data_out, mem_ready, mem_hit
    );

    modport slave (
        input  mem_addr, mem_data_in, mem_read, mem_write,
        output mem_data_out, mem_ready, mem_hit
    );
endinterface

// File: rtl/main_memory.sv
// Block-addressed backing memory below L2 with fixed read/write latency.
// Define MAIN_MEMORY_OPEN_BLOCK_EN to add the one-entry open-block buffer (mem_hit fast path).
module main_memory #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int BLOCK_SIZE    = 16,
    parameter int NUM_BLOCKS    = 256,
    parameter int READ_LATENCY  = 20,
    parameter int WRITE_LATENCY = 20
) (
    input  logic         clk,
    input  logic         rst,
    main_memory_if.slave bus
);
    localparam int OFF_W   = $clog2(BLOCK_SIZE);
    localparam int IDX_W   = $clog2(NUM_BLOCKS);
    localparam int BLK_W   = BLOCK_SIZE * DATA_WIDTH;
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_BUSY, S_HIT_RESP, S_RESP, S_RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             wr_q, wr_d;
    logic [BLK_W-1:0] wdata_q, wdata_d;
    logic [BLK_W-1:0] dout_q, dout_d;
    logic             mem_ready_q, mem_ready_d;
    logic             mem_hit_q, mem_hit_d;

    logic [IDX_W-1:0] req_idx;
    logic             unused_addr;
    logic             commit;
    logic             mem_we;
    logic [BLK_W-1:0] commit_data;
    logic [BLK_W-1:0] init_pat;
    logic [BLK_W-1:0] rd_q;
    logic [BLK_W-1:0] rd_block;
    logic             buf_match;
    logic [BLK_W-1:0] buf_data;

    // The RAM holds data XOR the power-up pattern, so an all-zero array reads
    // back as word w of block b = b*BLOCK_SIZE + w without any init pass.
    logic [BLK_W-1:0] mem_array [NUM_BLOCKS] = '{default: '0};

    assign req_idx     = bus.mem_addr[OFF_W +: IDX_W];
    assign unused_addr = ^{bus.mem_addr[OFF_W-1:0], bus.mem_addr[ADDR_WIDTH-1:OFF_W+IDX_W]};

    for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : g_pat
        assign init_pat[gi*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'({idx_q, OFF_W'(gi)});
    end

    assign rd_block    = rd_q ^ init_pat;
    assign commit      = (state_q == S_BUSY) && (cnt_q == '0);
    assign mem_we      = commit && wr_q;
    assign commit_data = wr_q ? wdata_q : rd_block;

    // Read port runs every cycle on the latched index; latency >= 2 guarantees
    // rd_q is settled before the BUSY expiry edge.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_array[idx_q] <= wdata_q ^ init_pat;
        end
        rd_q <= mem_array[idx_q];
    end

`ifdef MAIN_MEMORY_OPEN_BLOCK_EN
    logic             buf_valid_q, buf_valid_d;
    logic [IDX_W-1:0] buf_idx_q, buf_idx_d;
    logic [BLK_W-1:0] buf_data_q, buf_data_d;

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_idx_d   = buf_idx_q;
        buf_data_d  = buf_data_q;
        if (commit) begin
            buf_valid_d = 1'b1;
            buf_idx_d   = idx_q;
            buf_data_d  = commit_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_idx_q   <= '0;
            buf_data_q  <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_idx_q   <= buf_idx_d;
            buf_data_q  <= buf_data_d;
        end
    end

    assign buf_match = buf_valid_q && (buf_idx_q == req_idx);
    assign buf_data  = buf_data_q;
`else
    assign buf_match = 1'b0;
    assign buf_data  = '0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        dout_d      = dout_q;
        mem_ready_d = 1'b0;
        mem_hit_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.mem_read || bus.mem_write) begin
                    idx_d   = req_idx;
                    wr_d    = bus.mem_write;
                    wdata_d = bus.mem_data_in;
                    cnt_d   = bus.mem_write ? WR_LOAD : RD_LOAD;
                    state_d = (!bus.mem_write && buf_match) ? S_HIT_RESP : S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    mem_ready_d = 1'b1;
                    state_d     = S_RESP;
                    if (!wr_q) begin
                        dout_d = rd_block;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            // One lookup cycle so the hit pulse lands after the edge following acceptance.
            S_HIT_RESP: begin
                mem_hit_d = 1'b1;
                dout_d    = buf_data;
                state_d   = S_RESP;
            end
            S_RESP: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!bus.mem_read && !bus.mem_write) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            dout_q      <= '0;
            mem_ready_q <= 1'b0;
            mem_hit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            dout_q      <= dout_d;
            mem_ready_q <= mem_ready_d;
            mem_hit_q   <= mem_hit_d;
        end
    end

    assign bus.mem_data_out = dout_q;
    assign bus.mem_ready    = mem_ready_q;
    assign bus.mem_hit      = mem_hit_q;
endmodule

// File: tb/tb_main_memory.sv
// Self-checking bench for main_memory against a block-level reference model.
`timescale 1ns/1ps
module tb_main_memory;
    localparam int DW      = 32;
    localparam int AW      = 32;
    localparam int BS      = 16;
    localparam int NB      = 256;
    localparam int RL      = 20;
    localparam int WL      = 20;
    localparam int BLK_W   = BS * DW;
    localparam int TIMEOUT = 60;
`ifdef MAIN_MEMORY_OPEN_BLOCK_EN
    localparam bit OPEN = 1'b1;
`else
    localparam bit OPEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    main_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS)) bus ();

    main_memory #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS),
        .NUM_BLOCKS(NB), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    // Reference model: word array, open-buffer tag, last returned block.
    logic [DW-1:0]    mm [NB][BS];
    bit               buf_v;
    int               buf_i;
    logic [BLK_W-1:0] last_out;

    bit               o_got, o_ready, o_hit;
    int               o_lat, o_pulses;
    logic [BLK_W-1:0] o_data;
    bit               e_hit;
    int               e_lat;
    logic [BLK_W-1:0] e_data;

    function automatic logic [BLK_W-1:0] model_block(int b);
        logic [BLK_W-1:0] v;
        for (int w = 0; w < BS; w++) v[w*DW +: DW] = mm[b][w];
        return v;
    endfunction

    function automatic logic [BLK_W-1:0] rand_block();
        logic [BLK_W-1:0] v;
        for (int w = 0; w < BS; w++) v[w*DW +: DW] = $urandom;
        return v;
    endfunction

    task automatic model_txn(input logic [AW-1:0] addr, input bit wr, input logic [BLK_W-1:0] wdata);
        int b;
        b     = int'((addr / BS) % NB);
        e_hit = OPEN && buf_v && !wr && (b == buf_i);
        e_lat = e_hit ? 1 : (wr ? WL : RL);
        if (wr) begin
            for (int w = 0; w < BS; w++) mm[b][w] = wdata[w*DW +: DW];
            e_data = last_out;
        end else begin
            e_data   = model_block(b);
            last_out = e_data;
        end
        if (!e_hit) begin
            buf_v = 1'b1;
            buf_i = b;
        end
    endtask

    // Drives one request (held until the response plus 'hold' extra cycles) and records what came back.
    task automatic do_txn(input logic [AW-1:0] addr, input bit rd, input bit wr,
                          input logic [BLK_W-1:0] wdata, input int hold);
        @(negedge clk);
        bus.mem_addr    = addr;
        bus.mem_data_in = wdata;
        bus.mem_read    = rd;
        bus.mem_write   = wr;
        @(posedge clk);
        #2;
        bus.mem_addr    = $urandom;
        bus.mem_data_in = rand_block();
        o_got = 1'b0; o_ready = 1'b0; o_hit = 1'b0; o_lat = 0; o_data = '0;
        while (!o_got && o_lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            o_lat++;
            if (bus.mem_ready || bus.mem_hit) begin
                o_got   = 1'b1;
                o_ready = bus.mem_ready;
                o_hit   = bus.mem_hit;
                o_data  = bus.mem_data_out;
            end
        end
        o_pulses = o_got ? 1 : 0;
        repeat (hold) begin
            @(posedge clk);
            #1;
            if (bus.mem_ready || bus.mem_hit) o_pulses++;
        end
        @(negedge clk);
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.mem_ready || bus.mem_hit) o_pulses++;
        end
        n_txn++;
        $display("txn %0d: addr=%h rd=%0d wr=%0d ready=%0d hit=%0d lat=%0d pulses=%0d",
                 n_txn, addr, rd, wr, o_ready, o_hit, o_lat, o_pulses);
    endtask

    task automatic test_reset();
        bus.mem_addr = '0; bus.mem_data_in = '0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.mem_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b, want 0", bus.mem_ready); end
        n_checks++;
        if (bus.mem_hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %b, want 0", bus.mem_hit); end
        n_checks++;
        if (bus.mem_data_out !== '0) begin n_fail++; $display("FAIL reset_data: got %h, want 0", bus.mem_data_out); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Directed sequence: (addr, rd, wr, hold) rows sharing one comparison block.
    task automatic test_directed(input string name, input logic [AW-1:0] addrs[], input bit rds[],
                                 input bit wrs[], input int holds[]);
        logic [BLK_W-1:0] wd;
        for (int i = 0; i < addrs.size(); i++) begin
            wd = rand_block();
            do_txn(addrs[i], rds[i], wrs[i], wd, holds[i]);
            model_txn(addrs[i], wrs[i], wd);
            n_checks++;
            if (o_hit !== e_hit || o_ready !== !e_hit) begin
                n_fail++;
                $display("FAIL %s_path[%0d]: ready=%0d hit=%0d, want hit=%0d", name, i, o_ready, o_hit, e_hit);
            end
            n_checks++;
            if (o_lat != e_lat) begin n_fail++; $display("FAIL %s_latency[%0d]: got %0d, want %0d", name, i, o_lat, e_lat); end
            n_checks++;
            if (o_data !== e_data) begin n_fail++; $display("FAIL %s_data[%0d]: got %h, want %h", name, i, o_data, e_data); end
            n_checks++;
            if (o_pulses != 1) begin n_fail++; $display("FAIL %s_pulses[%0d]: got %0d, want 1", name, i, o_pulses); end
        end
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        bus.mem_addr = 32'h80; bus.mem_data_in = rand_block(); bus.mem_write = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.mem_ready !== 1'b0 || bus.mem_hit !== 1'b0) begin
            n_fail++; $display("FAIL midrst_pulses: ready=%b hit=%b, want 0 0", bus.mem_ready, bus.mem_hit);
        end
        n_checks++;
        if (bus.mem_data_out !== '0) begin n_fail++; $display("FAIL midrst_data: got %h, want 0", bus.mem_data_out); end
        @(negedge clk);
        bus.mem_write = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        buf_v    = 1'b0;
        last_out = '0;
        test_directed("midrst_read", '{32'h80, 32'h87}, '{1'b1, 1'b1}, '{1'b0, 1'b0}, '{0, 0});
    endtask

    task automatic test_random(input int n);
        logic [AW-1:0]    addr;
        logic [BLK_W-1:0] wd;
        bit               rd, wr;
        int               b, hold;
        for (int i = 0; i < n; i++) begin
            b    = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, NB - 1);
            addr = AW'(($urandom_range(0, 255) * NB + b) * BS + $urandom_range(0, BS - 1));
            case ($urandom_range(0, 5))
                0, 1:    begin rd = 1'b0; wr = 1'b1; end
                2:       begin rd = 1'b1; wr = 1'b1; end
                default: begin rd = 1'b1; wr = 1'b0; end
            endcase
            hold = $urandom_range(0, 2);
            wd   = rand_block();
            do_txn(addr, rd, wr, wd, hold);
            model_txn(addr, wr, wd);
            n_checks++;
            if (o_hit !== e_hit || o_ready !== !e_hit) begin
                n_fail++;
                $display("FAIL rand_path[%0d]: ready=%0d hit=%0d, want hit=%0d", i, o_ready, o_hit, e_hit);
            end
            n_checks++;
            if (o_lat != e_lat) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d, want %0d", i, o_lat, e_lat); end
            n_checks++;
            if (o_data !== e_data) begin n_fail++; $display("FAIL rand_data[%0d]: got %h, want %h", i, o_data, e_data); end
            n_checks++;
            if (o_pulses != 1) begin n_fail++; $display("FAIL rand_pulses[%0d]: got %0d, want 1", i, o_pulses); end
        end
    endtask

    initial begin
        for (int b = 0; b < NB; b++)
            for (int w = 0; w < BS; w++) mm[b][w] = DW'(b * BS + w);
        buf_v    = 1'b0;
        buf_i    = 0;
        last_out = '0;

        test_reset();
        test_directed("first_read", '{32'h35}, '{1'b1}, '{1'b0}, '{0});
        test_directed("write_read", '{32'h120, 32'h12F}, '{1'b0, 1'b1}, '{1'b1, 1'b0}, '{0, 0});
        test_directed("open_buffer", '{32'h40, 32'h50, 32'h50}, '{1'b1, 1'b1, 1'b1},
                      '{1'b0, 1'b0, 1'b0}, '{0, 0, 0});
        test_directed("hold_level", '{32'h64, 32'h64, 32'h1A0}, '{1'b1, 1'b1, 1'b1},
                      '{1'b0, 1'b0, 1'b0}, '{3, 3, 0});
        test_directed("both_high", '{32'h200, 32'h20F}, '{1'b1, 1'b1}, '{1'b1, 1'b0}, '{0, 0});
        test_reset_mid_write();
        test_random(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
